snake_game_ctrl: RTL and testbench
==================================

# snake_game_ctrl

Sequencer for the snake head on the 160x120 play grid. It generates the move-step timebase and applies the player's direction requests. It updates the head coordinates that drive the wall collision detector, then samples that detector's `hit_wall` result to decide between continuing play and game over. It sits between the input/debounce logic and the collision detector/renderer.

## Interface
- `GRID_COLS`, 160, grid width in cells; head_x range 0..GRID_COLS-1
- `GRID_ROWS`, 120, grid height in cells; head_y range 0..GRID_ROWS-1
- `TICK_DIV`, 1000000, clocks per move step; must be >= 2
- `START_X`, 80, head x loaded in IDLE
- `START_Y`, 60, head y loaded in IDLE
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  level sampled per cycle; starts game (IDLE) / returns to IDLE (OVER)
- `dir_valid`  in  1  direction request strobe
- `dir_req`  in  2  requested direction: 00 up (y-1), 01 right (x+1), 10 down (y+1), 11 left (x-1)
- `hit_wall`  in  1  combinational wall-collision result for the current head_x/head_y
- `head_x`  out  8  registered head column
- `head_y`  out  7  registered head row
- `step`  out  1  one-cycle pulse, high in the cycle after head_x/head_y change
- `game_over`  out  1  high while in OVER
- `state`  out  2  IDLE=0, RUN=1, CHECK=2, OVER=3
- `steps_cnt`  out  16  completed steps this game, saturating

## Operation
- Reset values:
  - state IDLE; head_x=START_X, head_y=START_Y
  - cur_dir=pend_dir=01 (right)
  - step=0, game_over=0, steps_cnt=0, tick counter=0
- **Direction handling.** A request is accepted when dir_valid=1 and dir_req != cur_dir^2'b10; accepted requests write pend_dir.
  - Reversal requests are dropped silently.
  - Requests are accepted in IDLE, RUN and CHECK and ignored in OVER.
  - The reversal filter compares against cur_dir, the direction last applied, not against pend_dir.
  - When several requests are accepted between steps, the last one wins.
- **IDLE**
  - Holds head at START_X/START_Y, tick counter=0, steps_cnt=0, cur_dir=right.
  - pend_dir is held, so a pre-start request is honoured.
  - start=1 -> RUN.
- **RUN**
  - Tick counter increments each cycle and wraps TICK_DIV-1 -> 0.
  - In the cycle the counter equals TICK_DIV-1:
    - cur_dir<=pend_dir
    - head updated by ±1 on the axis of pend_dir
    - steps_cnt+1, saturating at 0xFFFF
    - -> CHECK
- **CHECK**
  - Lasts one cycle; the tick counter keeps counting.
  - Samples hit_wall for the new head: 1 -> OVER, 0 -> RUN.
- **OVER**
  - game_over=1; head, steps_cnt and counter frozen.
  - start=1 -> IDLE, which reloads the start position on entry.
- start is ignored in RUN and CHECK.
- **Arithmetic.** Coordinates are unsigned and no wrap-around is performed. Border cells (x=0, x=GRID_COLS-1, y=0, y=GRID_ROWS-1) are walls, so OVER is entered before any coordinate can leave range.
- **Reset mid-operation.** Returns immediately to the reset values, independent of clk.

## Timing
- Step period is exactly TICK_DIV cycles. The first head change lands on the TICK_DIV-th rising edge after the edge that enters RUN.
- step is a 1-cycle pulse, asserted during CHECK.
- A collision is reflected in state/game_over 2 edges after the head update: the head edge, then the CHECK edge.
- A direction request accepted up to and including the cycle where the counter equals TICK_DIV-1 takes effect on that step.

## Configuration
- `SNAKE_GAME_CTRL_PAUSE_EN` defined:
  - Adds input `pause` (1 bit).
  - While pause=1 in RUN: the tick counter holds, no step occurs, and direction requests are still accepted.
  - pause has no effect in IDLE, CHECK or OVER.
- Undefined: no `pause` port; the counter never freezes.

## Test plan
- Default run, TICK_DIV=4, rst then start:
  - step pulses every 4 cycles; head 80,60 -> 81,60 -> ...
  - The 79th step gives head_x=159 -> OVER, game_over=1, steps_cnt=79, head holds 159,60.
- Reversal filter, in RUN with cur_dir right:
  - dir_req=11 is ignored; the next step gives x+1.
  - Then dir_req=00 is accepted; the next step gives y=59.
- Last-wins: dir_req=10 then dir_req=00 within one step interval (cur right) -> the next step moves up, y-1.
- Vertical wall: from 80,60 request up -> after 60 steps head 80,0 -> OVER. start -> IDLE: head 80,60, game_over=0, steps_cnt=0. start again -> RUN.
- Async reset asserted mid-RUN between clock edges -> outputs return to reset values immediately; start after release restarts normally.
- With SNAKE_GAME_CTRL_PAUSE_EN, TICK_DIV=4:
  - pause=1 for 10 cycles in RUN -> no step and head unchanged.
  - After release, the next step comes after the remaining count.

Source files
------------

// File: rtl/snake_game_ctrl_if.sv
// Signal bundle between the snake sequencer and its input/collision/render neighbours.
// The pause signal exists only when SNAKE_GAME_CTRL_PAUSE_EN is defined.
interface snake_game_ctrl_if;
  logic        start;
  logic        dir_valid;
  logic [1:0]  dir_req;
  logic        hit_wall;
  logic [7:0]  head_x;
  logic [6:0]  head_y;
  logic        step;
  logic        game_over;
  logic [1:0]  state;
  logic [15:0] steps_cnt;
`ifdef SNAKE_GAME_CTRL_PAUSE_EN
  logic        pause;

  modport master (
    output start, dir_valid, dir_req, hit_wall, pause,
    input  head_x, head_y, step, game_over, state, steps_cnt
  );

  modport slave (
    input  start, dir_valid, dir_req, hit_wall, pause,
    output head_x, head_y, step, game_over, state, steps_cnt
  );
`else
  modport master (
    output start, dir_valid, dir_req, hit_wall,
    input  head_x, head_y, step, game_over, state, steps_cnt
  );

  modport slave (
    input  start, dir_valid, dir_req, hit_wall,
    output head_x, head_y, step, game_over, state, steps_cnt
  );
`endif
endinterface

// File: rtl/snake_game_ctrl.sv
// Snake head sequencer: move timebase, direction filtering, head update and wall check.
// Optional pause input enabled by defining SNAKE_GAME_CTRL_PAUSE_EN.
module snake_game_ctrl #(
  parameter int unsigned GRID_COLS = 160,
  parameter int unsigned GRID_ROWS = 120,
  parameter int unsigned TICK_DIV  = 1000000,
  parameter int unsigned START_X   = 80,
  parameter int unsigned START_Y   = 60
) (
  input  logic               clk,
  input  logic               rst,
  snake_game_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2,
    OVER  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  localparam int unsigned     CNT_W    = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [7:0]      X0       = 8'(START_X);
  localparam logic [6:0]      Y0       = 7'(START_Y);

  if (GRID_COLS > 256 || GRID_ROWS > 128 || TICK_DIV < 2) begin : g_param_check
    $error("snake_game_ctrl: parameters out of range");
  end

  state_t           state_q, state_d;
  dir_t             cur_dir_q, pend_dir_q, eff_dir;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       head_x_q, nxt_x;
  logic [6:0]       head_y_q, nxt_y;
  logic [15:0]      steps_q;
  logic             step_q;
  logic             run_en;
  logic             dir_accept;
  logic             tick;

`ifdef SNAKE_GAME_CTRL_PAUSE_EN
  assign run_en = ~bus.pause;
`else
  assign run_en = 1'b1;
`endif

  // A request arriving in the tick cycle itself must steer that step, so the
  // step direction bypasses pend_dir when a request is accepted this cycle.
  always_comb begin
    dir_accept = bus.dir_valid && (state_q != OVER) &&
                 (bus.dir_req != (cur_dir_q ^ 2'b10));
    eff_dir    = dir_accept ? dir_t'(bus.dir_req) : pend_dir_q;
    tick       = (state_q == RUN) && run_en && (cnt_q == CNT_LAST);
  end

  always_comb begin
    nxt_x = head_x_q;
    nxt_y = head_y_q;
    unique case (eff_dir)
      DIR_UP:    nxt_y = head_y_q - 7'd1;
      DIR_RIGHT: nxt_x = head_x_q + 8'd1;
      DIR_DOWN:  nxt_y = head_y_q + 7'd1;
      DIR_LEFT:  nxt_x = head_x_q - 8'd1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (bus.start) state_d = RUN;
      RUN:   if (tick)      state_d = CHECK;
      CHECK: state_d = bus.hit_wall ? OVER : RUN;
      OVER:  if (bus.start) state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_x_q   <= X0;
      head_y_q   <= Y0;
      cur_dir_q  <= DIR_RIGHT;
      pend_dir_q <= DIR_RIGHT;
      cnt_q      <= '0;
      steps_q    <= '0;
      step_q     <= 1'b0;
    end else begin
      step_q <= tick;
      if (dir_accept) pend_dir_q <= dir_t'(bus.dir_req);
      unique case (state_q)
        IDLE: begin
          head_x_q  <= X0;
          head_y_q  <= Y0;
          cur_dir_q <= DIR_RIGHT;
          cnt_q     <= '0;
          steps_q   <= '0;
        end
        RUN: begin
          if (run_en) cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
          if (tick) begin
            cur_dir_q <= eff_dir;
            head_x_q  <= nxt_x;
            head_y_q  <= nxt_y;
            if (steps_q != '1) steps_q <= steps_q + 16'd1;
          end
        end
        CHECK: cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        OVER: begin
          // Reload on the leaving edge so IDLE shows the start position immediately.
          if (bus.start) begin
            head_x_q  <= X0;
            head_y_q  <= Y0;
            cur_dir_q <= DIR_RIGHT;
            cnt_q     <= '0;
            steps_q   <= '0;
          end
        end
      endcase
    end
  end

  assign bus.head_x    = head_x_q;
  assign bus.head_y    = head_y_q;
  assign bus.step      = step_q;
  assign bus.game_over = (state_q == OVER);
  assign bus.state     = state_q;
  assign bus.steps_cnt = steps_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed bench for snake_game_ctrl with TICK_DIV=4 and a behavioural border detector.
module tb_snake_game_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  snake_game_ctrl_if bus ();

  snake_game_ctrl #(
    .GRID_COLS(160), .GRID_ROWS(120), .TICK_DIV(4), .START_X(80), .START_Y(60)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Wall collision detector: border cells of the 160x120 grid.
  assign bus.hit_wall = (bus.head_x == 8'd0) || (bus.head_x == 8'd159) ||
                        (bus.head_y == 7'd0) || (bus.head_y == 7'd119);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_head(input string tag, input int x, input int y);
    check({tag, "_x"}, 32'(bus.head_x), 32'(x));
    check({tag, "_y"}, 32'(bus.head_y), 32'(y));
  endtask

  task automatic req(input logic [1:0] d);
    bus.dir_valid = 1'b1;
    bus.dir_req   = d;
    cyc(1);
    bus.dir_valid = 1'b0;
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.dir_valid = 1'b0;
    bus.dir_req   = 2'b00;
`ifdef SNAKE_GAME_CTRL_PAUSE_EN
    bus.pause     = 1'b0;
`endif
    cyc(2);
    check("rst_state", 32'(bus.state), 0);
    check_head("rst_head", 80, 60);
    check("rst_step", 32'(bus.step), 0);
    check("rst_go", 32'(bus.game_over), 0);
    check("rst_steps", 32'(bus.steps_cnt), 0);
    rst = 1'b0;
    cyc(2);
    check("idle_hold", 32'(bus.state), 0);

    // Horizontal run into the right wall.
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    check("run_entry", 32'(bus.state), 1);
    cyc(3);
    check_head("pre_step1", 80, 60);
    check("pre_step1_pulse", 32'(bus.step), 0);
    cyc(1);
    check_head("step1", 81, 60);
    check("step1_pulse", 32'(bus.step), 1);
    check("step1_state", 32'(bus.state), 2);
    check("step1_cnt", 32'(bus.steps_cnt), 1);
    cyc(1);
    check("step1_back_run", 32'(bus.state), 1);
    check("step1_pulse_end", 32'(bus.step), 0);
    cyc(3);
    check_head("step2", 82, 60);
    cyc(4 * 76);
    check_head("step78", 158, 60);
    check("step78_state", 32'(bus.state), 2);
    cyc(4);
    check_head("step79", 159, 60);
    check("step79_state", 32'(bus.state), 2);
    check("step79_go", 32'(bus.game_over), 0);
    cyc(1);
    check("hwall_state", 32'(bus.state), 3);
    check("hwall_go", 32'(bus.game_over), 1);
    cyc(10);
    check_head("over_hold", 159, 60);
    check("over_steps", 32'(bus.steps_cnt), 79);
    check("over_step", 32'(bus.step), 0);
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    check("over_idle", 32'(bus.state), 0);
    check_head("over_idle", 80, 60);
    check("over_idle_go", 32'(bus.game_over), 0);
    check("over_idle_steps", 32'(bus.steps_cnt), 0);

    // Vertical run: pre-start request up into the top wall.
    req(2'b00);
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    cyc(4);
    check_head("up1", 80, 59);
    cyc(4 * 58);
    check_head("up59", 80, 1);
    cyc(4);
    check_head("up60", 80, 0);
    check("up60_steps", 32'(bus.steps_cnt), 60);
    cyc(1);
    check("vwall_state", 32'(bus.state), 3);
    bus.start = 1'b1;
    cyc(1);
    check("vwall_idle", 32'(bus.state), 0);
    check_head("vwall_idle", 80, 60);
    check("vwall_idle_go", 32'(bus.game_over), 0);
    check("vwall_idle_steps", 32'(bus.steps_cnt), 0);
    cyc(1);
    bus.start = 1'b0;
    check("restart_run", 32'(bus.state), 1);
    cyc(4);
    check_head("restart_step", 80, 59);
    cyc(1);

    // Asynchronous reset between clock edges.
    #2 rst = 1'b1;
    #1;
    check("arst_state", 32'(bus.state), 0);
    check_head("arst_head", 80, 60);
    check("arst_steps", 32'(bus.steps_cnt), 0);
    check("arst_go", 32'(bus.game_over), 0);
    cyc(1);
    rst = 1'b0;

    // Reversal filter, start ignored in RUN, last-wins, late request.
    bus.start = 1'b1;
    cyc(1);
    check("rev_run", 32'(bus.state), 1);
    bus.dir_valid = 1'b1;
    bus.dir_req   = 2'b11;
    cyc(1);
    bus.dir_valid = 1'b0;
    bus.start     = 1'b0;
    check("start_ignored", 32'(bus.state), 1);
    cyc(2);
    check_head("rev_pre", 80, 60);
    cyc(1);
    check_head("rev_step", 81, 60);
    req(2'b00);
    cyc(3);
    check_head("up_step", 81, 59);
    check("up_steps", 32'(bus.steps_cnt), 2);
    req(2'b01);
    cyc(3);
    check_head("right_step", 82, 59);
    req(2'b10);
    req(2'b00);
    cyc(2);
    check_head("last_wins", 82, 58);
    check("last_wins_steps", 32'(bus.steps_cnt), 4);
    cyc(3);
    check_head("late_pre", 82, 58);
    req(2'b01);
    check_head("late_req", 83, 58);
    check("late_steps", 32'(bus.steps_cnt), 5);
    cyc(1);

`ifdef SNAKE_GAME_CTRL_PAUSE_EN
    bus.pause = 1'b1;
    cyc(10);
    check_head("paused", 83, 58);
    check("paused_state", 32'(bus.state), 1);
    check("paused_step", 32'(bus.step), 0);
    bus.pause = 1'b0;
    cyc(2);
    check_head("resume_pre", 83, 58);
    cyc(1);
    check_head("resume_step", 84, 58);
    check("resume_steps", 32'(bus.steps_cnt), 6);
`else
    cyc(3);
    check_head("free_step", 84, 58);
    check("free_steps", 32'(bus.steps_cnt), 6);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
